// File: rtl/forward_scoreboard_pkg.sv
//==== forward_scoreboard_pkg: shared constants, slot flags and select-width helper (rev 1.0) ====
`default_nettype none

package forward_scoreboard_pkg;

  localparam int XZR           = 31;
  localparam int DEF_ADDRW     = 5;
  localparam int DEF_DEPTH     = 3;
  localparam int DEF_LOADSTAGE = 2;

  // Per-slot status bits; the destination address is held alongside in its own array.
  typedef struct packed {
    logic valid;
    logic isload;
  } slot_flags_t;

  function automatic int sel_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/forward_scoreboard_if.sv
//==== forward_scoreboard_if: issue/operand/forward bundle between ID stage and scoreboard (rev 1.0) ====
`default_nettype none

interface forward_scoreboard_if #(
  parameter int NREAD = 2,
  parameter int ADDRW = 5,
  parameter int SELW  = 2
);
  logic                    issue_valid;
  logic                    issue_regwrite;
  logic                    issue_isload;
  logic [ADDRW-1:0]        issue_rd;
  logic                    flush;
  logic [NREAD*ADDRW-1:0]  rd_addr;
  logic [NREAD-1:0]        rd_used;
  logic [NREAD-1:0]        fwd_use;
  logic [NREAD*SELW-1:0]   fwd_src;
  logic                    stall;

  modport master (
    output issue_valid, issue_regwrite, issue_isload, issue_rd, flush, rd_addr, rd_used,
    input  fwd_use, fwd_src, stall
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_isload, issue_rd, flush, rd_addr, rd_used,
    output fwd_use, fwd_src, stall
  );
endinterface

`default_nettype wire

// File: rtl/forward_scoreboard_fwd_port_match.sv
//==== fwd_port_match: youngest-producer search for one read port over the tracked slots (rev 1.0) ====
`default_nettype none

module fwd_port_match
  import forward_scoreboard_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDRW     = DEF_ADDRW,
  parameter int LOADSTAGE = DEF_LOADSTAGE,
  parameter int ZEROREG   = XZR,
  parameter int SELW      = sel_width(DEF_DEPTH)
) (
  input  logic [DEPTH-1:0]            slot_valid,
  input  logic [DEPTH-1:0]            slot_isload,
  input  logic [DEPTH-1:0][ADDRW-1:0] slot_rd,
  input  logic [ADDRW-1:0]            addr,
  output logic                        hit,
  output logic                        avail,
  output logic [SELW-1:0]             idx
);

  // Scan oldest to youngest so the last assignment is the youngest match.
  always_comb begin
    hit   = 1'b0;
    avail = 1'b0;
    idx   = '0;
    if (addr != ADDRW'(ZEROREG)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_valid[k] && (slot_rd[k] == addr)) begin
          hit   = 1'b1;
          avail = !slot_isload[k] || ((k + 1) >= LOADSTAGE);
          idx   = SELW'(k);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/forward_scoreboard.sv
//==== forward_scoreboard: operand-forwarding and load-use hazard unit beside ID/EX (rev 1.0) ====
`default_nettype none

module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int NREAD     = 2,
  parameter int ADDRW     = DEF_ADDRW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LOADSTAGE = DEF_LOADSTAGE,
  parameter int ZEROREG   = XZR
) (
  input  logic          clk,
  input  logic          reset,
  forward_scoreboard_if.slave bus
);

  localparam int SELW = sel_width(DEPTH);

  slot_flags_t [DEPTH-1:0]     slot_flags;
  logic [DEPTH-1:0][ADDRW-1:0] slot_rd;
  logic [DEPTH-1:0]            slot_valid;
  logic [DEPTH-1:0]            slot_isload;

  logic [NREAD-1:0]            hit;
  logic [NREAD-1:0]            avail;
  logic [NREAD-1:0][SELW-1:0]  idx;
  logic [NREAD-1:0]            stall_req;
  logic [NREAD-1:0]            fwd_use_w;
  logic [NREAD*SELW-1:0]       fwd_src_w;
  logic                        stall_w;
  logic                        issue_ok;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_valid[k]  = slot_flags[k].valid;
      slot_isload[k] = slot_flags[k].isload;
    end
  end

  generate
    for (genvar p = 0; p < NREAD; p++) begin : g_port
      fwd_port_match #(
        .DEPTH     (DEPTH),
        .ADDRW     (ADDRW),
        .LOADSTAGE (LOADSTAGE),
        .ZEROREG   (ZEROREG),
        .SELW      (SELW)
      ) u_match (
        .slot_valid  (slot_valid),
        .slot_isload (slot_isload),
        .slot_rd     (slot_rd),
        .addr        (bus.rd_addr[p*ADDRW +: ADDRW]),
        .hit         (hit[p]),
        .avail       (avail[p]),
        .idx         (idx[p])
      );
    end
  endgenerate

  always_comb begin
    fwd_use_w = '0;
    fwd_src_w = '0;
    stall_req = '0;
    for (int p = 0; p < NREAD; p++) begin
      fwd_use_w[p] = hit[p] & avail[p];
      if (hit[p] && avail[p]) begin
        fwd_src_w[p*SELW +: SELW] = idx[p];
      end
      stall_req[p] = hit[p] & ~avail[p] & bus.rd_used[p];
    end
  end

  assign stall_w     = bus.issue_valid & (|stall_req);
  assign bus.fwd_use = fwd_use_w;
  assign bus.fwd_src = fwd_src_w;
  assign bus.stall   = stall_w;

  assign issue_ok = bus.issue_valid & ~stall_w & ~bus.flush & bus.issue_regwrite
                  & (bus.issue_rd != ADDRW'(ZEROREG));

  // A flush squashes both the issuing instruction and whatever is leaving slot 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_flags <= '0;
      slot_rd    <= '0;
    end else begin
      slot_flags[0].valid  <= issue_ok;
      slot_flags[0].isload <= issue_ok & bus.issue_isload;
      slot_rd[0]           <= bus.issue_rd;
      for (int k = 1; k < DEPTH; k++) begin
        slot_flags[k].valid  <= slot_flags[k-1].valid & ~((k == 1) & bus.flush);
        slot_flags[k].isload <= slot_flags[k-1].isload;
        slot_rd[k]           <= slot_rd[k-1];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_forward_scoreboard.sv
//==== tb_forward_scoreboard: table-driven directed vectors for forward_scoreboard (rev 1.0) ====
`default_nettype none

module tb_forward_scoreboard;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  forward_scoreboard_if #(.NREAD(2), .ADDRW(5), .SELW(2)) bus ();

  forward_scoreboard #(
    .NREAD     (2),
    .ADDRW     (5),
    .DEPTH     (3),
    .LOADSTAGE (2),
    .ZEROREG   (31)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic       rw;
    logic       ld;
    logic [4:0] rd;
    logic       fl;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [1:0] used;
    logic [1:0] fu;
    logic [1:0] s0;
    logic [1:0] s1;
    logic       st;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic v(input int rst, input int iv, input int rw, input int ld, input int rd,
                   input int fl, input int a0, input int a1, input int used,
                   input int fu, input int s0, input int s1, input int st);
    vec_t t;
    t.rst = 1'(rst); t.iv = 1'(iv); t.rw = 1'(rw); t.ld = 1'(ld); t.rd = 5'(rd);
    t.fl = 1'(fl); t.a0 = 5'(a0); t.a1 = 5'(a1); t.used = 2'(used);
    t.fu = 2'(fu); t.s0 = 2'(s0); t.s1 = 2'(s1); t.st = 1'(st);
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    reset              = t.rst;
    bus.issue_valid    = t.iv;
    bus.issue_regwrite = t.rw;
    bus.issue_isload   = t.ld;
    bus.issue_rd       = t.rd;
    bus.flush          = t.fl;
    bus.rd_addr        = {t.a1, t.a0};
    bus.rd_used        = t.used;
  endtask

  task automatic chk(input string nm, input int i, input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      $display("FAIL %s vec %0d: got %b expected %b", nm, i, act, exp);
      n_miss++;
    end
  endtask

  task automatic run_vec(input vec_t t, input int i);
    drive(t);
    @(negedge clk);
    n_vec++;
    chk("fwd_use", i, {2'b00, bus.fwd_use}, {2'b00, t.fu});
    chk("fwd_src", i, bus.fwd_src, {t.s1, t.s0});
    chk("stall",   i, {3'b000, bus.stall}, {3'b000, t.st});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;
    //  rst iv rw ld rd fl a0  a1 used | fu s0 s1 st
    // reset, then a read of X3 with nothing in flight
    v(1, 0, 0, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0);
    v(1, 0, 0, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0,  0, 0,  3,  0, 1,   0, 0, 0, 0);
    // ALU back-to-back: ADD X1, then X1 ages through slots 1..3 and retires
    v(0, 1, 1, 0,  1, 0,  2,  3, 3,   0, 0, 0, 0);
    v(0, 1, 1, 0, 10, 0,  1,  0, 1,   1, 0, 0, 0);
    v(0, 1, 0, 0,  0, 0,  1,  0, 1,   1, 1, 0, 0);
    v(0, 1, 0, 0,  0, 0,  1,  0, 1,   1, 2, 0, 0);
    v(0, 1, 0, 0,  0, 0,  1,  0, 1,   0, 0, 0, 0);
    // load-use on port 1: one stall cycle, then forward from slot 2
    v(0, 1, 1, 1,  2, 0,  5,  6, 0,   0, 0, 0, 0);
    v(0, 1, 1, 0, 11, 0,  7,  2, 3,   0, 0, 0, 1);
    v(0, 1, 1, 0, 11, 0,  7,  2, 3,   2, 0, 1, 0);
    v(0, 0, 0, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 0, 0, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 0, 0, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0);
    // youngest wins: two ALU writers of X5
    v(0, 1, 1, 0,  5, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 1, 0,  5, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0,  0, 0,  5,  0, 1,   1, 0, 0, 0);
    v(0, 0, 0, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 0, 0, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0);
    // younger writer is a load: stall even though older ALU result is ready
    v(0, 1, 1, 0,  5, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 1, 1,  5, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0,  0, 0,  5,  0, 1,   0, 0, 0, 1);
    v(0, 1, 0, 0,  0, 0,  5,  0, 1,   1, 1, 0, 0);
    v(0, 0, 0, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0);
    // XZR never tracked; unused operand never stalls
    v(0, 1, 1, 1, 31, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0,  0, 0, 31, 31, 3,   0, 0, 0, 0);
    v(0, 1, 1, 1,  4, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0,  0, 0,  4,  0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0,  0, 0,  4,  0, 1,   1, 1, 0, 0);
    v(0, 1, 0, 0,  0, 0,  0,  4, 2,   2, 0, 2, 0);
    // stall is gated by issue_valid
    v(0, 1, 1, 1,  6, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 0, 0, 0,  0, 0,  6,  0, 1,   0, 0, 0, 0);
    v(0, 0, 0, 0,  0, 0,  6,  0, 1,   1, 1, 0, 0);
    v(0, 0, 0, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0);
    // flush squashes the issuing instruction
    v(0, 1, 1, 0,  7, 1,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0,  0, 0,  7,  0, 1,   0, 0, 0, 0);
    // flush squashes slot 1 as it shifts into slot 2
    v(0, 1, 1, 0,  8, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0,  0, 1,  8,  0, 1,   1, 0, 0, 0);
    v(0, 1, 0, 0,  0, 0,  8,  0, 1,   0, 0, 0, 0);
    // flush leaves slots 2+ intact
    v(0, 1, 1, 0,  9, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 1, 0, 12, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 0, 0, 0,  0, 1,  9, 12, 3,   3, 1, 0, 0);
    v(0, 0, 0, 0,  0, 0,  9, 12, 3,   1, 2, 0, 0);
    // simultaneous stall and flush drops the load in slot 1
    v(0, 1, 1, 1, 13, 0,  0,  0, 0,   0, 0, 0, 0);
    v(0, 1, 1, 0, 14, 1, 13,  0, 1,   0, 0, 0, 1);
    v(0, 1, 0, 0,  0, 0, 13, 14, 3,   0, 0, 0, 0);

    t = vecs[0];
    drive(t);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // reset asserted during a load-use stall clears the scoreboard at the next edge
    t = vecs[0];
    t.rst = 1'b0; t.iv = 1'b1; t.rw = 1'b1; t.ld = 1'b1; t.rd = 5'd3;
    t.a0 = 5'd0; t.a1 = 5'd0; t.used = 2'b00;
    t.fu = 2'b00; t.s0 = 2'd0; t.s1 = 2'd0; t.st = 1'b0;
    run_vec(t, 100);
    t.rst = 1'b1; t.rw = 1'b0; t.ld = 1'b0; t.rd = 5'd0; t.a0 = 5'd3; t.used = 2'b01;
    t.st = 1'b1;
    run_vec(t, 101);
    t.rst = 1'b0; t.st = 1'b0;
    run_vec(t, 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
